// File: rtl/cdb_arbiter.sv
`default_nettype none
// cdb_arbiter: round-robin Common Data Bus arbiter, one holding buffer per result source.
// Optional macro CDB_STATS_EN compiles saturating broadcast/conflict counters.
module cdb_arbiter #(
  parameter int               N_SRC       = 4,
  parameter int               TAG_W       = 4,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*TAG_W-1:0] src_tag,
  input  logic [N_SRC*32-1:0]    src_data,
  output logic [N_SRC-1:0]       src_ready,
  output logic [TAG_W+32-1:0]    cdb_out,
  output logic                   cdb_valid,
  output logic [31:0]            stat_bcast,
  output logic [31:0]            stat_conflict
);

  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0] hold_v;
  logic [TAG_W-1:0] hold_tag  [N_SRC];
  logic [31:0]      hold_data [N_SRC];
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic             any_grant;
  logic [N_SRC-1:0] grant;
  logic [N_SRC-1:0] accept;

  always_comb begin
    any_grant = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_SRC);
      if (!any_grant && hold_v[idx]) begin
        any_grant = 1'b1;
        winner    = idx;
      end
    end
  end

  assign grant     = any_grant ? (N_SRC'(1) << winner) : '0;
  // A granted buffer frees its slot this cycle, so the source may refill it at the same edge.
  assign src_ready = {N_SRC{~flush}} & (~hold_v | grant);

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign accept[i] = src_valid[i] && src_ready[i] &&
                         (src_tag[i*TAG_W +: TAG_W] != INVALID_TAG);
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_v <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (flush) begin
          hold_v[i] <= 1'b0;
        end else if (accept[i]) begin
          hold_v[i]    <= 1'b1;
          hold_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
          hold_data[i] <= src_data[i*32 +: 32];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr  <= '0;
      cdb_out <= {INVALID_TAG, 32'h0};
    end else if (flush) begin
      rr_ptr  <= '0;
      cdb_out <= {INVALID_TAG, 32'h0};
    end else if (any_grant) begin
      cdb_out <= {hold_tag[winner], hold_data[winner]};
      rr_ptr  <= (winner == PTR_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end else begin
      cdb_out <= {INVALID_TAG, 32'h0};
    end
  end

  assign cdb_valid = (cdb_out[TAG_W+31 -: TAG_W] != INVALID_TAG);

`ifdef CDB_STATS_EN
  logic launch;
  logic conflict;

  assign launch   = !flush && any_grant;
  assign conflict = !flush && (|(hold_v & (hold_v - 1'b1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_bcast    <= '0;
      stat_conflict <= '0;
    end else begin
      if (launch && (stat_bcast != 32'hFFFF_FFFF))
        stat_bcast <= stat_bcast + 32'd1;
      if (conflict && (stat_conflict != 32'hFFFF_FFFF))
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`else
  assign stat_bcast    = 32'h0;
  assign stat_conflict = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// tb_cdb_arbiter: table-driven and hand-sequenced checks with a broadcast scoreboard.
module tb_cdb_arbiter;

  localparam logic [3:0] INV = 4'hF;

  logic         CLK = 1'b0;
  logic         RST;
  logic         flush;
  logic [3:0]   src_valid;
  logic [15:0]  src_tag;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic [35:0]  cdb_out;
  logic         cdb_valid;
  logic [31:0]  stat_bcast;
  logic [31:0]  stat_conflict;

  int checks  = 0;
  int errors  = 0;
  int n_bcast = 0;
  logic [35:0] sbq[$];
  logic [35:0] mon_exp;
`ifdef CDB_STATS_EN
  logic [31:0] conf_snap;
`endif

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] tags;
    logic [3:0]  ready;
    logic        bc;
    logic [1:0]  bsrc;
    logic [3:0]  btag;
  } vec_t;
  vec_t vt[18];

  always #5 CLK = ~CLK;

  cdb_arbiter #(.N_SRC(4), .TAG_W(4), .INVALID_TAG(INV)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .cdb_out(cdb_out), .cdb_valid(cdb_valid),
    .stat_bcast(stat_bcast), .stat_conflict(stat_conflict)
  );

  function automatic logic [31:0] dat(input int s, input logic [3:0] t);
    return 32'hD000_0000 | (32'(s) << 16) | 32'(t);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] tg, input logic [3:0] rdy,
                              input logic bc, input logic [1:0] bs, input logic [3:0] bt);
    vec_t r;
    r.valid = v; r.tags = tg; r.ready = rdy; r.bc = bc; r.bsrc = bs; r.btag = bt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] tg);
    src_valid = v;
    src_tag   = tg;
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = dat(i, tg[i*4 +: 4]);
  endtask

  // Every broadcast must match the oldest outstanding expectation; extras are errors.
  always @(negedge CLK) begin
    if (!RST && cdb_valid) begin
      n_bcast++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bcast actual=%h expected=none", cdb_out);
      end else begin
        mon_exp = sbq.pop_front();
        if (cdb_out !== mon_exp) begin
          errors++;
          $display("FAIL bcast actual=%h expected=%h", cdb_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    // contention from rr_ptr=0
    vt[0]  = mk(4'b1111, 16'h4321, 4'b1111, 1'b0, 2'd0, 4'h0);
    vt[1]  = mk(4'b0000, 16'h0000, 4'b0001, 1'b1, 2'd0, 4'h1);
    vt[2]  = mk(4'b0000, 16'h0000, 4'b0011, 1'b1, 2'd1, 4'h2);
    vt[3]  = mk(4'b0000, 16'h0000, 4'b0111, 1'b1, 2'd2, 4'h3);
    vt[4]  = mk(4'b0000, 16'h0000, 4'b1111, 1'b1, 2'd3, 4'h4);
    // fairness: src0 streaming, src1 once
    vt[5]  = mk(4'b0001, 16'h0001, 4'b1111, 1'b0, 2'd0, 4'h0);
    vt[6]  = mk(4'b0011, 16'h0062, 4'b1111, 1'b1, 2'd0, 4'h1);
    vt[7]  = mk(4'b0001, 16'h0003, 4'b1110, 1'b1, 2'd1, 4'h6);
    vt[8]  = mk(4'b0001, 16'h0003, 4'b1111, 1'b1, 2'd0, 4'h2);
    vt[9]  = mk(4'b0000, 16'h0000, 4'b1111, 1'b1, 2'd0, 4'h3);
    // streaming on src3, then an INVALID-tag input that must be dropped
    vt[10] = mk(4'b1000, 16'h1000, 4'b1111, 1'b0, 2'd0, 4'h0);
    vt[11] = mk(4'b1000, 16'h2000, 4'b1111, 1'b1, 2'd3, 4'h1);
    vt[12] = mk(4'b1000, 16'h3000, 4'b1111, 1'b1, 2'd3, 4'h2);
    vt[13] = mk(4'b1000, 16'h4000, 4'b1111, 1'b1, 2'd3, 4'h3);
    vt[14] = mk(4'b0000, 16'h0000, 4'b1111, 1'b1, 2'd3, 4'h4);
    vt[15] = mk(4'b0000, 16'h0000, 4'b1111, 1'b0, 2'd0, 4'h0);
    vt[16] = mk(4'b0100, 16'h0F00, 4'b1111, 1'b0, 2'd0, 4'h0);
    vt[17] = mk(4'b0000, 16'h0000, 4'b1111, 1'b0, 2'd0, 4'h0);

    RST = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
    #12;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_tag", cdb_out[35:32], INV);
    chk("rst_ready", src_ready, 4'b1111);
    chk("rst_stat_bcast", stat_bcast, 32'h0);
    @(posedge CLK); #1 RST = 1'b0;

    // Test 1: async reset while three buffers are full
    drive(4'b0111, 16'h0321); #1;
    chk("fill_ready", src_ready, 4'b1111);
    tick;
    drive(4'b0000, 16'h0000); #1;
    chk("full3_ready", src_ready, 4'b1001);
    chk("full3_cdb_valid", cdb_valid, 1'b0);
    #1 RST = 1'b1;
    #1;
    chk("midrst_cdb_valid", cdb_valid, 1'b0);
    chk("midrst_cdb_tag", cdb_out[35:32], INV);
    chk("midrst_ready", src_ready, 4'b1111);
    @(posedge CLK); #1 RST = 1'b0;
    tick; tick;
    chk("postrst_lost", cdb_valid, 1'b0);

    // Test 2: single result on src2
    drive(4'b0100, 16'h0500);
    src_data[64 +: 32] = 32'hDEADBEEF;
    #1;
    chk("single_ready_a", src_ready[2], 1'b1);
    sbq.push_back({4'h5, 32'hDEADBEEF});
    tick;
    drive(4'b0000, 16'h0000); #1;
    chk("single_latency", cdb_valid, 1'b0);
    chk("single_ready_b", src_ready[2], 1'b1);
    tick;
    chk("single_bcast_valid", cdb_valid, 1'b1);
    chk("single_bcast_data", cdb_out, {4'h5, 32'hDEADBEEF});
    chk("single_ready_c", src_ready[2], 1'b1);
    tick;
    chk("single_once", cdb_valid, 1'b0);

    // Test 6: flush discards three held results
    drive(4'b1011, 16'h9087); #1;
    chk("flfill_ready", src_ready, 4'b1111);
    tick;
    drive(4'b0000, 16'h0000);
    flush = 1'b1;
    #1;
    chk("flush_ready", src_ready, 4'b0000);
`ifdef CDB_STATS_EN
    conf_snap = stat_conflict;
`endif
    tick;
    flush = 1'b0;
    #1;
    chk("flush_cdb_valid", cdb_valid, 1'b0);
    chk("flush_ready_after", src_ready, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("flush_idle%0d", c), cdb_valid, 1'b0);
    end
`ifdef CDB_STATS_EN
    chk("flush_conflict_frozen", stat_conflict, conf_snap);
`endif

    // Tests 3, 4, 5: table of per-cycle vectors
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].valid, vt[i].tags);
      #1;
      chk($sformatf("vec%0d_ready", i), src_ready, vt[i].ready);
      if (vt[i].bc) sbq.push_back({vt[i].btag, dat(int'(vt[i].bsrc), vt[i].btag)});
      tick;
      chk($sformatf("vec%0d_cdb_valid", i), cdb_valid, vt[i].bc);
    end
    tick;

    chk("sb_empty", sbq.size(), 0);
    chk("bcast_total", n_bcast, 13);
`ifdef CDB_STATS_EN
    chk("stat_bcast", stat_bcast, 32'd13);
    chk("stat_conflict", stat_conflict, 32'd4);
`else
    chk("stat_bcast_tied", stat_bcast, 32'h0);
    chk("stat_conflict_tied", stat_conflict, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
